// File: rtl/md5_search_controller.sv
// Command sequencer for the MD5 brute-force datapath: decodes host command words,
// holds the target digest and character range, sequences flush/run of the
// generator+core pipeline, counts checked candidates and latches the first match.
module md5_search_controller #(
  parameter int unsigned PIPE_DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [31:0]  cmd_data,
  output logic         cmd_ready,
  output logic         rsp_valid,
  output logic [31:0]  rsp_data,
  input  logic         rsp_ready,
  output logic         gen_reset,
  output logic [7:0]   range_min,
  output logic [7:0]   range_max,
  input  logic [127:0] digest,
  output logic         capture,
  output logic         matched,
  output logic         busy
);

  localparam logic [31:0] CmdStop   = 32'h5230_0000;
  localparam logic [31:0] CmdStart  = 32'h5230_0001;
  localparam logic [31:0] CmdSetA   = 32'h5230_1000;
  localparam logic [31:0] CmdSetB   = 32'h5230_1001;
  localparam logic [31:0] CmdSetC   = 32'h5230_1002;
  localparam logic [31:0] CmdSetD   = 32'h5230_1003;
  localparam logic [31:0] CmdSetRng = 32'h5230_2000;
  localparam logic [31:0] CmdGetLo  = 32'h5230_3000;
  localparam logic [31:0] CmdGetHi  = 32'h5230_3001;
  localparam logic [31:0] CmdStatus = 32'h5230_3002;

  localparam int unsigned FlushW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StFlush = 2'd1, StRun = 2'd2, StDone = 2'd3} state_e;
  typedef enum logic [2:0] {OpNone, OpA, OpB, OpC, OpD, OpRange} op_e;

  state_e              state_q;
  op_e                 op_q;
  logic [31:0]         a_q, b_q, c_q, d_q;
  logic [7:0]          range_min_q, range_max_q;
  logic [63:0]         count_q;
  logic [31:0]         shadow_q;
  logic [FlushW-1:0]   flush_q;
  logic                matched_q, capture_q, err_cfg_q, err_range_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_data_q;
  logic                cmd_accept;

  assign cmd_ready  = !rsp_valid_q;
  assign cmd_accept = cmd_valid && !rsp_valid_q;
  assign busy       = (state_q == StFlush) || (state_q == StRun);
  assign gen_reset  = (state_q == StIdle) || (state_q == StDone);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign range_min  = range_min_q;
  assign range_max  = range_max_q;
  assign capture    = capture_q;
  assign matched    = matched_q;

  // Sequencer: pipeline progress first, then the accepted command overrides the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= OpNone;
      a_q         <= 32'hFFFF_FFFF;
      b_q         <= 32'h0;
      c_q         <= 32'h0;
      d_q         <= 32'h0;
      range_min_q <= 8'h61;
      range_max_q <= 8'h7A;
      count_q     <= 64'h0;
      shadow_q    <= 32'h0;
      flush_q     <= '0;
      matched_q   <= 1'b0;
      capture_q   <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_range_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      capture_q <= 1'b0;
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

      case (state_q)
        StFlush: begin
          // Digests still in flight belong to no candidate; skip comparing them.
          if (flush_q == FlushW'(PIPE_DEPTH - 1)) state_q <= StRun;
          else flush_q <= flush_q + FlushW'(1);
        end
        StRun: begin
          count_q <= count_q + 64'd1;
          if (digest == {a_q, b_q, c_q, d_q}) begin
            matched_q <= 1'b1;
            capture_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        default: ;
      endcase

      if (cmd_accept) begin
        if (op_q != OpNone) begin
          // Word following a SET_* is always its operand, whatever its value.
          op_q <= OpNone;
          if (busy) begin
            err_cfg_q <= 1'b1;
          end else begin
            case (op_q)
              OpA:     a_q <= cmd_data;
              OpB:     b_q <= cmd_data;
              OpC:     c_q <= cmd_data;
              OpD:     d_q <= cmd_data;
              OpRange: begin
                range_min_q <= cmd_data[7:0];
                range_max_q <= cmd_data[15:8];
              end
              default: ;
            endcase
          end
        end else begin
          case (cmd_data)
            CmdStop:   state_q <= StIdle;
            CmdStart: begin
              if (!busy) begin
                if (range_min_q <= range_max_q) begin
                  count_q     <= 64'h0;
                  matched_q   <= 1'b0;
                  err_cfg_q   <= 1'b0;
                  err_range_q <= 1'b0;
                  flush_q     <= '0;
                  state_q     <= StFlush;
                end else begin
                  err_range_q <= 1'b1;
                end
              end
            end
            CmdSetA:   op_q <= OpA;
            CmdSetB:   op_q <= OpB;
            CmdSetC:   op_q <= OpC;
            CmdSetD:   op_q <= OpD;
            CmdSetRng: op_q <= OpRange;
            CmdGetLo: begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= count_q[31:0];
              shadow_q    <= count_q[63:32];
            end
            CmdGetHi: begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= shadow_q;
            end
            CmdStatus: begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {27'd0, err_range_q, err_cfg_q, matched_q, state_q};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/md5_search_controller.md
# md5_search_controller

Synchronous command sequencer for the MD5 brute-force datapath (printable chunk generator feeding the 64-stage MD5 core). It accepts 32-bit command words from the host link with a valid/ready handshake and holds the target digest and character range. It starts, stops and flushes the generator/core pipeline, compares digests, counts checked candidates and latches the first match. This replaces edge-triggered command capture with a single-clock design.

## Interface

- PIPE_DEPTH, 64: cycles from generator output to matching digest at the core output.
- clk  in  1  the design clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command word present.
- cmd_data  in  32  command or operand word.
- cmd_ready  out  1  controller accepts cmd_data this cycle.
- rsp_valid  out  1  response word valid.
- rsp_data  out  32  response word.
- rsp_ready  in  1  host consumes the response.
- gen_reset  out  1  holds the generator in reset (active-high).
- range_min, range_max  out  8 each  character range for the generator.
- digest  in  128  core output {a,b,c,d}, a in [127:96].
- capture  out  1  one-cycle pulse when a match is latched (the datapath freezes its text buffer on this).
- matched  out  1  sticky match flag.
- busy  out  1  high in FLUSH or RUN.

## Operation

- Commands: 0x52300000 STOP, 0x52300001 START, 0x52301000–3 SET_A..D (each takes 1 operand), 0x52302000 SET_RANGE (1 operand: min=[7:0], max=[15:8]), 0x52303000 GET_CNT_LO, 0x52303001 GET_CNT_HI, 0x52303002 GET_STATUS. 0x00000000 and unknown words are consumed and ignored, with no response.
- Operand capture: after a SET_* command the next accepted word is always the operand, even if it equals a command code.
- Operand rejection: an operand arriving while busy is discarded and sets the sticky err_cfg.
- States:
  - IDLE: gen_reset=1.
  - START in IDLE/DONE with range_min<=range_max: clear count, matched and err_cfg, then go to FLUSH. Otherwise set err_range and stay in IDLE.
  - FLUSH: gen_reset=0. A counter runs PIPE_DEPTH cycles with no compares, then the state goes to RUN.
  - RUN: each cycle, count += 1. If digest=={A,B,C,D}, set matched, pulse capture and go to DONE. The matching candidate is included in count.
  - DONE: gen_reset=1, count frozen.
  - STOP in any state: go to IDLE, count frozen, matched kept.
- Count is 64 bits and wraps to 0 with no flag.
- GET_CNT_LO returns count[31:0] and snapshots count[63:32] into a shadow register. GET_CNT_HI returns the shadow, which keeps the pair coherent while running. GET_CNT_HI without a prior LO returns the shadow's reset value of 0.
- GET_STATUS response bits: [1:0] state (0 IDLE, 1 FLUSH, 2 RUN, 3 DONE), [2] matched, [3] err_cfg, [4] err_range. All other bits are 0.
- Error flags: err_* clear only on reset or a successful START.
- Reset values: A=0xFFFFFFFF, B=C=D=0, range_min=0x61, range_max=0x7A, state IDLE, gen_reset=1, count=0, shadow=0, matched=0, capture=0, rsp_valid=0, rsp_data=0, cmd_ready=1, busy=0, err flags 0.

## Timing

- Transfers: a command transfers when cmd_valid&&cmd_ready. A response transfers when rsp_valid&&rsp_ready.
- Backpressure: cmd_ready=!rsp_valid, so at most one response is outstanding and no GET command is accepted while one is pending.
- Response latency: rsp_valid rises the cycle after a GET is accepted. rsp_data is stable until the response is consumed.
- State transitions take effect the cycle after the command is accepted.
- STOP and START latency: gen_reset changes the same cycle the state changes.
- Match latency: capture and matched assert 1 cycle after the matching digest is sampled. busy drops on that cycle too.
- Match and STOP together: if a digest match and a STOP acceptance occur in the same RUN cycle, the match is latched and the state goes to IDLE.
- Reset mid-operation: asynchronous. All outputs go to their reset values immediately, and any pending response is dropped.

## Test plan

- Post-reset: GET_STATUS -> rsp_data=0x00000000. Write SET_RANGE with operand 0x00007A61, then read back through behaviour: range_min=0x61, range_max=0x7A.
- Flush and count: START, hold digest constant non-matching for 200 cycles, STOP, then GET_CNT_LO -> 200-PIPE_DEPTH (136), and GET_CNT_HI -> 0.
- Match: set A..D=0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210; START; drive that digest at RUN cycle 10 -> capture pulses once, matched=1, GET_STATUS -> 0x7, count=10.
- Flush mask: a matching digest driven only during FLUSH -> no capture, state reaches RUN.
- Errors:
  - SET_RANGE operand 0x00006170 then START -> stays IDLE, status bit4=1.
  - SET_A during RUN -> operand discarded, A unchanged, status bit3=1.
- Handshake and reset: GET_CNT_LO with rsp_ready held low for 5 cycles -> cmd_ready=0 throughout and rsp_data stable. Assert reset mid-RUN -> all outputs at reset values the same cycle.
